// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, flag bit positions and FSM state encoding.
package cpu_alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADC = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_CMP = 4'b0111;
  localparam logic [3:0] OP_RLC = 4'b1000;
  localparam logic [3:0] OP_RRC = 4'b1001;
  localparam logic [3:0] OP_RAL = 4'b1010;
  localparam logic [3:0] OP_RAR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_S = 2;
  localparam int FLG_P = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/cpu_alu_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module cpu_alu_mul
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               run,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int unsigned LAST = WIDTH - 1;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   cnt;
  logic [WIDTH:0]     sum;

  // Add to the high half, then shift the whole accumulator right by one.
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    prod = {sum, acc[WIDTH-1:1]};
    done = run && (32'(cnt) == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      acc    <= prod;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_alu_seq.sv
// Registered ALU with internal C/Z/S/P flag register and valid/ready issue.
// Define CPU_ALU_MUL_EN to build the iterative multiplier (opcode 1100) and its FSM.
module cpu_alu_seq
  import cpu_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] h,
  output logic             res_vld,
  output logic             c,
  output logic             z,
  output logic             s,
  output logic             p,
  output state_t           dbg_state
);

  // Handshake: a request transfers on a rising edge where req_vld && req_rdy;
  // x/y/op are sampled only then. res_vld pulses for one cycle per result.

  logic [3:0]       flags;
  logic [3:0]       flg_nxt;
  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] res_e;
  logic             res_c;
  logic             upd_zsp;
  logic             accept;

  assign c = flags[FLG_C];
  assign z = flags[FLG_Z];
  assign s = flags[FLG_S];
  assign p = flags[FLG_P];
  assign accept = req_vld && req_rdy;

  // Single-cycle datapath; rotates touch only C, reserved opcodes touch nothing.
  always_comb begin
    arith   = '0;
    res_e   = x;
    res_c   = flags[FLG_C];
    upd_zsp = 1'b0;
    case (op)
      OP_ADD: begin arith = {1'b0, x} + {1'b0, y}; res_e = arith[WIDTH-1:0]; res_c = arith[WIDTH]; upd_zsp = 1'b1; end
      OP_ADC: begin arith = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, flags[FLG_C]}; res_e = arith[WIDTH-1:0]; res_c = arith[WIDTH]; upd_zsp = 1'b1; end
      OP_SUB: begin arith = {1'b0, x} - {1'b0, y}; res_e = arith[WIDTH-1:0]; res_c = arith[WIDTH]; upd_zsp = 1'b1; end
      OP_SBB: begin arith = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, flags[FLG_C]}; res_e = arith[WIDTH-1:0]; res_c = arith[WIDTH]; upd_zsp = 1'b1; end
      OP_AND: begin res_e = x & y; res_c = 1'b0; upd_zsp = 1'b1; end
      OP_XOR: begin res_e = x ^ y; res_c = 1'b0; upd_zsp = 1'b1; end
      OP_OR:  begin res_e = x | y; res_c = 1'b0; upd_zsp = 1'b1; end
      OP_CMP: begin arith = {1'b0, x} - {1'b0, y}; res_e = arith[WIDTH-1:0]; res_c = arith[WIDTH]; upd_zsp = 1'b1; end
      OP_RLC: begin res_e = {x[WIDTH-2:0], x[WIDTH-1]}; res_c = x[WIDTH-1]; end
      OP_RRC: begin res_e = {x[0], x[WIDTH-1:1]}; res_c = x[0]; end
      OP_RAL: begin res_e = {x[WIDTH-2:0], flags[FLG_C]}; res_c = x[WIDTH-1]; end
      OP_RAR: begin res_e = {flags[FLG_C], x[WIDTH-1:1]}; res_c = x[0]; end
      default: ;
    endcase
    flg_nxt        = flags;
    flg_nxt[FLG_C] = res_c;
    if (upd_zsp) begin
      flg_nxt[FLG_Z] = (res_e == '0);
      flg_nxt[FLG_S] = res_e[WIDTH-1];
      flg_nxt[FLG_P] = ~^res_e;
    end
    // CMP reports the flags of the subtraction but returns the accumulator.
    if (op == OP_CMP) res_e = x;
  end

`ifdef CPU_ALU_MUL_EN
  state_t               state;
  logic                 mul_start;
  logic                 mul_done;
  logic [2*WIDTH-1:0]   mul_prod;

  assign mul_start = accept && (op == OP_MUL);
  assign req_rdy   = (state == ST_IDLE);
  assign dbg_state = state;

  cpu_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .run   (state == ST_MUL),
    .a     (x),
    .b     (y),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      e       <= '0;
      h       <= '0;
      flags   <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state <= ST_MUL;
          end else if (accept) begin
            e       <= res_e;
            h       <= '0;
            flags   <= flg_nxt;
            res_vld <= 1'b1;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state        <= ST_IDLE;
            e            <= mul_prod[WIDTH-1:0];
            h            <= mul_prod[2*WIDTH-1:WIDTH];
            flags[FLG_C] <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
            flags[FLG_Z] <= (mul_prod[WIDTH-1:0] == '0);
            flags[FLG_S] <= mul_prod[WIDTH-1];
            flags[FLG_P] <= ~^mul_prod[WIDTH-1:0];
            res_vld      <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`else
  assign req_rdy   = 1'b1;
  assign dbg_state = ST_IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e       <= '0;
      h       <= '0;
      flags   <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (accept) begin
        e       <= res_e;
        h       <= '0;
        flags   <= flg_nxt;
        res_vld <= 1'b1;
      end
    end
  end
`endif

endmodule
